// File: rtl/cache_fill_ctrl_pkg.sv
// Shared types and constants for the cache miss sequencer / memory arbiter.
package cache_fill_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic TGT_I = 1'b0;
  localparam logic TGT_D = 1'b1;

  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int WORD_IDX_BITS     = 3;

endpackage

// File: rtl/cache_fill_ctrl_fill_counter.sv
// Saturating word-index counter with synchronous clear and terminal detect.
module cache_fill_ctrl_fill_counter
  import cache_fill_ctrl_pkg::*;
#(
  parameter int LAST = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  output logic [WORD_IDX_BITS-1:0] cnt,
  output logic                     tc
);

  assign tc = (cnt == WORD_IDX_BITS'(LAST));

  // Count up while enabled, stop at LAST, clear whenever the fill is not active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + WORD_IDX_BITS'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss-handling sequencer: arbitrates I/D misses and D write-through stores onto
// one pipelined word-wide memory and streams 8-word blocks into the caches.
module cache_fill_ctrl
  import cache_fill_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int TIMEOUT         = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     icache_miss,
  input  logic [ADDR_WIDTH-1:0]    icache_miss_addr,
  input  logic                     dcache_miss,
  input  logic [ADDR_WIDTH-1:0]    dcache_miss_addr,
  input  logic                     dcache_wr_req,
  input  logic [ADDR_WIDTH-1:0]    dcache_wr_addr,
  input  logic [15:0]              dcache_wr_data,
  output logic                     dcache_wr_ack,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [15:0]              mem_data_out,
  input  logic                     mem_data_valid,
  input  logic [15:0]              mem_data_in,
  output logic                     fill_we,
  output logic                     fill_target,
  output logic [2:0]               fill_word,
  output logic [15:0]              fill_data,
  output logic [ADDR_WIDTH-1:0]    fill_addr,
  output logic                     meta_we,
  output logic                     fill_done,
  output logic                     icache_stall,
  output logic                     dcache_stall,
  output logic                     fill_err
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK =
    {{(ADDR_WIDTH-BLOCK_OFFSET_BITS){1'b1}}, {BLOCK_OFFSET_BITS{1'b0}}};

  state_t                   state;
  logic                     issue_done;
  logic [WD_W-1:0]          wd_cnt;
  logic                     in_fill;
  logic                     issuing;
  logic [WORD_IDX_BITS-1:0] issue_cnt;
  logic [WORD_IDX_BITS-1:0] ret_cnt;
  logic                     issue_tc;
  logic                     ret_tc;

  assign in_fill = (state == FILL);
  assign issuing = in_fill && !issue_done;
  assign fill_we = in_fill && mem_data_valid;

  cache_fill_ctrl_fill_counter #(.LAST(WORDS_PER_BLOCK - 1)) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!in_fill),
    .en    (issuing),
    .cnt   (issue_cnt),
    .tc    (issue_tc)
  );

  cache_fill_ctrl_fill_counter #(.LAST(WORDS_PER_BLOCK - 1)) u_ret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!in_fill),
    .en    (fill_we),
    .cnt   (ret_cnt),
    .tc    (ret_tc)
  );

  // Sequencer: fixed-priority grant in IDLE, block fill with watchdog, done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fill_addr   <= '0;
      fill_target <= TGT_I;
      issue_done  <= 1'b0;
      wd_cnt      <= '0;
      fill_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          issue_done <= 1'b0;
          wd_cnt     <= '0;
          if (dcache_wr_req) begin
            state <= WRITE;
          end else if (dcache_miss) begin
            state       <= FILL;
            fill_target <= TGT_D;
            fill_addr   <= dcache_miss_addr & BLOCK_MASK;
          end else if (icache_miss) begin
            state       <= FILL;
            fill_target <= TGT_I;
            fill_addr   <= icache_miss_addr & BLOCK_MASK;
          end else begin
            state <= IDLE;
          end
        end
        WRITE: begin
          state <= IDLE;
        end
        FILL: begin
          if (issuing && issue_tc) begin
            issue_done <= 1'b1;
          end else begin
            issue_done <= issue_done;
          end
          if (mem_data_valid && ret_tc) begin
            state <= DONE;
          end else if (mem_data_valid) begin
            wd_cnt <= '0;
          end else if (issue_done) begin
            // Watchdog only runs once every read is out and memory goes quiet.
            if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
              fill_err <= 1'b1;
              state    <= IDLE;
            end else begin
              wd_cnt <= wd_cnt + WD_W'(1);
            end
          end else begin
            wd_cnt <= wd_cnt;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory port drive: single store in WRITE, back-to-back block reads in FILL.
  always_comb begin
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_out = 16'h0000;
    case (state)
      WRITE: begin
        mem_en       = 1'b1;
        mem_wr       = 1'b1;
        mem_addr     = dcache_wr_addr;
        mem_data_out = dcache_wr_data;
      end
      FILL: begin
        if (issuing) begin
          mem_en   = 1'b1;
          mem_addr = fill_addr + ADDR_WIDTH'({issue_cnt, 1'b0});
        end else begin
          mem_en   = 1'b0;
          mem_addr = '0;
        end
      end
      default: begin
        mem_en   = 1'b0;
        mem_addr = '0;
      end
    endcase
  end

  assign fill_word     = fill_we ? ret_cnt : 3'd0;
  assign fill_data     = fill_we ? mem_data_in : 16'h0000;
  assign meta_we       = (state == DONE);
  assign fill_done     = (state == DONE);
  assign dcache_wr_ack = (state == WRITE);

  // Stalls are qualified by rst_n so every output reads 0 while reset is held.
  assign icache_stall = rst_n & icache_miss & ~(fill_done & (fill_target == TGT_I));
  assign dcache_stall = rst_n & ((dcache_miss & ~(fill_done & (fill_target == TGT_D))) |
                                 (dcache_wr_req & ~dcache_wr_ack));

endmodule
